nco_sweep_ctrl: RTL and testbench

Phase-increment sweep generator for the swept-source NCO path. Drives the NCO's `phi_inc_i` with a stepped linear chirp: start increment, signed step, step count and per-step dwell. Supports single-shot or continuous repetition, and emits a sweep-start trigger for the acquisition logic. Sits directly upstream of the sin/cos NCO and runs on the same clock and clock-enable.

---
 rtl/nco_sweep_pkg.sv | 20 ++
 rtl/nco_dwell_cnt.sv | 43 ++++
 rtl/nco_sweep_ctrl.sv | 132 +++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/nco_sweep_pkg.sv
// +--------------------------------------------------------------------+
// | nco_sweep_pkg : shared types and default widths for the NCO sweeper |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package nco_sweep_pkg;

  localparam int APR = 32;
  localparam int NSW = 16;
  localparam int DWW = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

endpackage

`default_nettype wire

// File: rtl/nco_dwell_cnt.sv
// +--------------------------------------------------------------------+
// | nco_dwell_cnt : per-value dwell counter, wraps at max(dwell,1)-1    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module nco_dwell_cnt #(
  parameter int DWW = nco_sweep_pkg::DWW
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clken,
  input  logic           clr_i,
  input  logic [DWW-1:0] dwell_i,
  output logic           tc_o
);

  logic [DWW-1:0] cnt_q;
  logic [DWW-1:0] cnt_d;
  logic [DWW-1:0] last_cnt;

  // A dwell of zero behaves as a dwell of one.
  assign last_cnt = (dwell_i == '0) ? '0 : dwell_i - DWW'(1);
  assign tc_o     = (cnt_q == last_cnt);

  always_comb begin
    cnt_d = cnt_q + DWW'(1);
    if (clr_i || tc_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clken) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/nco_sweep_ctrl.sv
// +--------------------------------------------------------------------+
// | nco_sweep_ctrl : stepped linear-chirp phase-increment generator     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module nco_sweep_ctrl #(
  parameter int APR = nco_sweep_pkg::APR,
  parameter int NSW = nco_sweep_pkg::NSW,
  parameter int DWW = nco_sweep_pkg::DWW
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clken,
  input  logic           start_i,
  input  logic           abort_i,
  input  logic [APR-1:0] cfg_start_i,
  input  logic [APR-1:0] cfg_step_i,
  input  logic [NSW-1:0] cfg_nsteps_i,
  input  logic [DWW-1:0] cfg_dwell_i,
  input  logic           cfg_cont_i,
  output logic [APR-1:0] phi_inc_o,
  output logic           sweep_trig_o,
  output logic           busy_o,
  output logic           done_o,
  output logic [NSW-1:0] step_idx_o
);

  import nco_sweep_pkg::*;

  sweep_state_e   state_q;
  logic [APR-1:0] start_q;
  logic [APR-1:0] step_q;
  logic [NSW-1:0] nsteps_q;
  logic [DWW-1:0] dwell_q;
  logic           cont_q;
  logic [APR-1:0] phi_q;
  logic [NSW-1:0] idx_q;
  logic           trig_q;
  logic           busy_q;
  logic           done_q;

  logic           dwell_tc;
  logic           dwell_clr;
  logic           last_idx;

  // Hold the dwell counter at zero outside a sweep so value 0 gets a full dwell.
  assign dwell_clr = (state_q != SWEEP) || abort_i;
  assign last_idx  = (idx_q == nsteps_q - NSW'(1));

  nco_dwell_cnt #(
    .DWW (DWW)
  ) u_dwell (
    .clk     (clk),
    .reset_n (reset_n),
    .clken   (clken),
    .clr_i   (dwell_clr),
    .dwell_i (dwell_q),
    .tc_o    (dwell_tc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      start_q  <= '0;
      step_q   <= '0;
      nsteps_q <= '0;
      dwell_q  <= '0;
      cont_q   <= 1'b0;
      phi_q    <= '0;
      idx_q    <= '0;
      trig_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (clken) begin
      trig_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          phi_q <= '0;
          idx_q <= '0;
          if (start_i && !abort_i && (cfg_nsteps_i != '0)) begin
            state_q  <= SWEEP;
            start_q  <= cfg_start_i;
            step_q   <= cfg_step_i;
            nsteps_q <= cfg_nsteps_i;
            dwell_q  <= cfg_dwell_i;
            cont_q   <= cfg_cont_i;
            phi_q    <= cfg_start_i;
            trig_q   <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        SWEEP: begin
          if (abort_i) begin
            state_q <= IDLE;
            phi_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end else if (dwell_tc) begin
            if (!last_idx) begin
              phi_q <= phi_q + step_q;
              idx_q <= idx_q + NSW'(1);
            end else if (cont_q) begin
              phi_q  <= start_q;
              idx_q  <= '0;
              trig_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              phi_q   <= '0;
              idx_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign phi_inc_o    = phi_q;
  assign step_idx_o   = idx_q;
  assign sweep_trig_o = trig_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_nco_sweep_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_nco_sweep_ctrl : directed vector bench for nco_sweep_ctrl        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clken;
  logic        start_i;
  logic        abort_i;
  logic [31:0] cfg_start_i;
  logic [31:0] cfg_step_i;
  logic [15:0] cfg_nsteps_i;
  logic [15:0] cfg_dwell_i;
  logic        cfg_cont_i;
  logic [31:0] phi_inc_o;
  logic        sweep_trig_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] step_idx_o;

  nco_sweep_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clken        (clken),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .cfg_start_i  (cfg_start_i),
    .cfg_step_i   (cfg_step_i),
    .cfg_nsteps_i (cfg_nsteps_i),
    .cfg_dwell_i  (cfg_dwell_i),
    .cfg_cont_i   (cfg_cont_i),
    .phi_inc_o    (phi_inc_o),
    .sweep_trig_o (sweep_trig_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .step_idx_o   (step_idx_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        ab;
    logic        ce;
    logic [31:0] cs;
    logic [31:0] cstep;
    logic [15:0] cn;
    logic [15:0] cd;
    logic        cc;
    logic [31:0] e_phi;
    logic [15:0] e_idx;
    logic        e_trig;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] cur_s, cur_step;
  logic [15:0] cur_n, cur_d;
  logic        cur_c;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic void set_cfg(logic [31:0] s, logic [31:0] stp, logic [15:0] n,
                                  logic [15:0] d, logic c);
    cur_s = s; cur_step = stp; cur_n = n; cur_d = d; cur_c = c;
  endfunction

  function automatic void add(logic st, logic ab, logic ce, logic [31:0] phi,
                              logic [15:0] idx, logic trig, logic busy, logic done);
    vec_t v;
    v.st = st; v.ab = ab; v.ce = ce;
    v.cs = cur_s; v.cstep = cur_step; v.cn = cur_n; v.cd = cur_d; v.cc = cur_c;
    v.e_phi = phi; v.e_idx = idx; v.e_trig = trig; v.e_busy = busy; v.e_done = done;
    vq.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_all(string tag, logic [31:0] phi, logic [15:0] idx,
                         logic trig, logic busy, logic done);
    chk({tag, " phi"},  phi_inc_o, phi);
    chk({tag, " idx"},  {16'd0, step_idx_o}, {16'd0, idx});
    chk({tag, " trig"}, {31'd0, sweep_trig_o}, {31'd0, trig});
    chk({tag, " busy"}, {31'd0, busy_o}, {31'd0, busy});
    chk({tag, " done"}, {31'd0, done_o}, {31'd0, done});
  endtask

  initial begin
    // Up-chirp 1000 +10, 4 values, dwell 3, single shot.
    set_cfg(32'd1000, 32'd10, 16'd4, 16'd3, 1'b0);
    add(1, 0, 1, 32'd1000, 16'd0, 1, 1, 0);
    for (int k = 2; k <= 12; k++) begin
      add(0, 0, 1, 32'd1000 + 32'd10 * 32'((k - 1) / 3), 16'((k - 1) / 3), 0, 1, 0);
    end
    add(0, 0, 1, 32'd0, 16'd0, 0, 0, 1);
    // Down-chirp with silent wrap, started in the done cycle.
    set_cfg(32'd3, 32'hFFFF_FFFB, 16'd2, 16'd1, 1'b0);
    add(1, 0, 1, 32'd3,          16'd0, 1, 1, 0);
    add(0, 0, 1, 32'hFFFF_FFFE, 16'd1, 0, 1, 0);
    add(0, 0, 1, 32'd0,          16'd0, 0, 0, 1);
    add(0, 0, 1, 32'd0,          16'd0, 0, 0, 0);
    // Dwell 0 acts as dwell 1.
    set_cfg(32'd100, 32'd1, 16'd3, 16'd0, 1'b0);
    add(1, 0, 1, 32'd100, 16'd0, 1, 1, 0);
    add(0, 0, 1, 32'd101, 16'd1, 0, 1, 0);
    add(0, 0, 1, 32'd102, 16'd2, 0, 1, 0);
    add(0, 0, 1, 32'd0,   16'd0, 0, 0, 1);
    // nsteps = 0 is ignored; start+abort in IDLE is ignored.
    set_cfg(32'd77, 32'd1, 16'd0, 16'd1, 1'b0);
    add(1, 0, 1, 32'd0, 16'd0, 0, 0, 0);
    add(1, 0, 1, 32'd0, 16'd0, 0, 0, 0);
    set_cfg(32'd77, 32'd1, 16'd2, 16'd1, 1'b0);
    add(1, 1, 1, 32'd0, 16'd0, 0, 0, 0);
    // Continuous, nsteps 2, dwell 1; mid-sweep start ignored; abort ends it.
    set_cfg(32'd50, 32'd7, 16'd2, 16'd1, 1'b1);
    add(1, 0, 1, 32'd50, 16'd0, 1, 1, 0);
    add(0, 0, 1, 32'd57, 16'd1, 0, 1, 0);
    add(1, 0, 1, 32'd50, 16'd0, 1, 1, 0);
    add(0, 0, 1, 32'd57, 16'd1, 0, 1, 0);
    add(0, 0, 1, 32'd50, 16'd0, 1, 1, 0);
    add(0, 1, 1, 32'd0,  16'd0, 0, 0, 0);
    add(0, 0, 1, 32'd0,  16'd0, 0, 0, 0);
    // clken gating: only enabled cycles count, outputs (pulses too) hold.
    set_cfg(32'd200, 32'd20, 16'd2, 16'd2, 1'b0);
    add(1, 0, 0, 32'd0,   16'd0, 0, 0, 0);
    add(1, 0, 1, 32'd200, 16'd0, 1, 1, 0);
    add(0, 0, 0, 32'd200, 16'd0, 1, 1, 0);
    add(0, 0, 1, 32'd200, 16'd0, 0, 1, 0);
    add(0, 0, 0, 32'd200, 16'd0, 0, 1, 0);
    add(0, 0, 1, 32'd220, 16'd1, 0, 1, 0);
    add(0, 0, 0, 32'd220, 16'd1, 0, 1, 0);
    add(0, 0, 1, 32'd220, 16'd1, 0, 1, 0);
    add(0, 0, 1, 32'd0,   16'd0, 0, 0, 1);
    add(0, 0, 0, 32'd0,   16'd0, 0, 0, 1);
    add(0, 0, 1, 32'd0,   16'd0, 0, 0, 0);

    reset_n = 1'b0; clken = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    cfg_start_i = '0; cfg_step_i = '0; cfg_nsteps_i = '0; cfg_dwell_i = '0; cfg_cont_i = 1'b0;
    tick();
    tick();
    chk_all("reset", 32'd0, 16'd0, 0, 0, 0);
    reset_n = 1'b1;
    tick();

    foreach (vq[i]) begin
      start_i = vq[i].st; abort_i = vq[i].ab; clken = vq[i].ce;
      cfg_start_i = vq[i].cs; cfg_step_i = vq[i].cstep; cfg_nsteps_i = vq[i].cn;
      cfg_dwell_i = vq[i].cd; cfg_cont_i = vq[i].cc;
      tick();
      chk_all($sformatf("v%0d", i), vq[i].e_phi, vq[i].e_idx, vq[i].e_trig,
              vq[i].e_busy, vq[i].e_done);
    end

    // Reset mid-sweep with clken low: reset wins, sweep discarded, no done.
    start_i = 1'b1; abort_i = 1'b0; clken = 1'b1;
    cfg_start_i = 32'd5; cfg_step_i = 32'd1; cfg_nsteps_i = 16'd4;
    cfg_dwell_i = 16'd2; cfg_cont_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    chk_all("pre-rst", 32'd6, 16'd1, 0, 1, 0);
    clken = 1'b0; reset_n = 1'b0;
    tick();
    chk_all("rst-mid", 32'd0, 16'd0, 0, 0, 0);
    reset_n = 1'b1; clken = 1'b1;
    tick();
    tick();
    chk_all("post-rst", 32'd0, 16'd0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
